// File: rtl/cpu_pkg.sv
// Shared constants and types for the register-file write path.
package cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 2;
  localparam int NUM_REGS   = 4;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant for the ALU and load writeback paths; grants are combinational.
// Ties go to A until the first accept after reset, then alternate against LastGrant.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_a_valid,
  input  logic i_l_valid,
  output logic o_a_grant,
  output logic o_l_grant
);

  req_e r_last;
  logic r_primed;
  logic w_tie_to_a;

  assign w_tie_to_a = !r_primed || (r_last == REQ_LOAD);
  assign o_a_grant  = !i_reset && i_a_valid && (!i_l_valid || w_tie_to_a);
  assign o_l_grant  = !i_reset && i_l_valid && (!i_a_valid || !w_tie_to_a);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last   <= REQ_ALU;
      r_primed <= 1'b0;
    end else if (o_a_grant) begin
      r_last   <= REQ_ALU;
      r_primed <= 1'b1;
    end else if (o_l_grant) begin
      r_last   <= REQ_LOAD;
      r_primed <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback; the accepted beat is driven one cycle later.
// Also tracks per-register in-flight writes so issue can stall; no backpressure from the register file.
module regfile_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = cpu_pkg::NUM_REGS
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_a_valid,
  input  logic [ADDR_WIDTH-1:0] i_a_rd,
  input  logic [DATA_WIDTH-1:0] i_a_wd,
  output logic                  o_a_ready,
  input  logic                  i_l_valid,
  input  logic [ADDR_WIDTH-1:0] i_l_rd,
  input  logic [DATA_WIDTH-1:0] i_l_wd,
  output logic                  o_l_ready,
  input  logic                  i_res_valid,
  input  logic [ADDR_WIDTH-1:0] i_res_reg,
  output logic                  o_reg_write,
  output logic [ADDR_WIDTH-1:0] o_rd,
  output logic [DATA_WIDTH-1:0] o_wd,
  output logic [NUM_REGS-1:0]   o_busy,
  output logic                  o_res_error
);

  logic                  w_a_grant;
  logic                  w_l_grant;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic                  w_res_clash;

  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_wd;
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_res_error;

  rr_arbiter2 u_arb (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_a_valid (i_a_valid),
    .i_l_valid (i_l_valid),
    .o_a_grant (w_a_grant),
    .o_l_grant (w_l_grant)
  );

  // Reservation is applied after the commit clear so a same-edge set wins.
  always_comb begin
    w_busy_nxt  = r_busy;
    w_res_clash = 1'b0;
    if (r_reg_write) w_busy_nxt[r_rd] = 1'b0;
    if (i_res_valid) begin
      w_res_clash = r_busy[i_res_reg] && !(r_reg_write && (r_rd == i_res_reg));
      w_busy_nxt[i_res_reg] = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wd        <= '0;
      r_busy      <= '0;
      r_res_error <= 1'b0;
    end else begin
      r_reg_write <= w_a_grant || w_l_grant;
      if (w_a_grant) begin
        r_rd <= i_a_rd;
        r_wd <= i_a_wd;
      end else if (w_l_grant) begin
        r_rd <= i_l_rd;
        r_wd <= i_l_wd;
      end
      r_busy <= w_busy_nxt;
      if (w_res_clash) r_res_error <= 1'b1;
    end
  end

  assign o_a_ready   = w_a_grant;
  assign o_l_ready   = w_l_grant;
  assign o_reg_write = r_reg_write;
  assign o_rd        = r_rd;
  assign o_wd        = r_wd;
  assign o_busy      = r_busy;
  assign o_res_error = r_res_error;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: expected register-file writes are queued at issue and checked by a monitor.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, l_valid, res_valid;
  logic [1:0]  a_rd, l_rd, res_reg;
  logic [15:0] a_wd, l_wd;
  logic        a_ready, l_ready, reg_write, res_error;
  logic [1:0]  rd;
  logic [15:0] wd;
  logic [3:0]  busy;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_a_valid   (a_valid),
    .i_a_rd      (a_rd),
    .i_a_wd      (a_wd),
    .o_a_ready   (a_ready),
    .i_l_valid   (l_valid),
    .i_l_rd      (l_rd),
    .i_l_wd      (l_wd),
    .o_l_ready   (l_ready),
    .i_res_valid (res_valid),
    .i_res_reg   (res_reg),
    .o_reg_write (reg_write),
    .o_rd        (rd),
    .o_wd        (wd),
    .o_busy      (busy),
    .o_res_error (res_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && reg_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d wd=%h expected none", rd, wd);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("write_rd", {30'd0, rd}, {30'd0, e[17:16]});
        check("write_wd", {16'd0, wd}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; a_valid = 1'b1; l_valid = 1'b0; res_valid = 1'b0;
    a_rd = '0; l_rd = '0; res_reg = '0; a_wd = '0; l_wd = '0;
    tick();
    @(negedge clk);
    check("ready_in_reset", {30'd0, a_ready, l_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_regwrite", {31'd0, reg_write}, 32'd0);
    check("idle_busy", {28'd0, busy}, 32'd0);
    check("idle_reserr", {31'd0, res_error}, 32'd0);
    check("idle_ready", {30'd0, a_ready, l_ready}, 32'd0);

    // Single ALU beat to an unreserved register.
    tick();
    a_valid = 1'b1; a_rd = 2'd2; a_wd = 16'h1234;
    exp_q.push_back({2'd2, 16'h1234});
    @(negedge clk);
    check("single_a_ready", {30'd0, a_ready, l_ready}, 32'd2);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("single_regwrite", {31'd0, reg_write}, 32'd1);
    tick();
    @(negedge clk);
    check("single_regwrite_off", {31'd0, reg_write}, 32'd0);
    check("hold_rd_wd", {14'd0, rd, wd}, {14'd0, 2'd2, 16'h1234});
    check("nonbusy_write_busy", {27'd0, res_error, busy}, 32'd0);

    // Back-to-back ALU writes to the same register, then a lone load beat.
    tick();
    a_valid = 1'b1; a_rd = 2'd1; a_wd = 16'h1111;
    exp_q.push_back({2'd1, 16'h1111});
    tick();
    a_wd = 16'h2222;
    exp_q.push_back({2'd1, 16'h2222});
    @(negedge clk);
    check("a_again_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    l_valid = 1'b1; l_rd = 2'd3; l_wd = 16'h0F0F;
    exp_q.push_back({2'd3, 16'h0F0F});
    @(negedge clk);
    check("only_l_ready", {30'd0, a_ready, l_ready}, 32'd1);
    tick();
    l_valid = 1'b0;
    tick();

    // Both streaming from reset: A first, then alternate.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_rd = 2'd1; a_wd = 16'hAAAA;
    l_valid = 1'b1; l_rd = 2'd3; l_wd = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back({2'd1, 16'hAAAA});
      else            exp_q.push_back({2'd3, 16'h5555});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_grant", {30'd0, a_ready, l_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
      if (i > 0) check("rr_regwrite_cont", {31'd0, reg_write}, 32'd1);
      tick();
    end
    a_valid = 1'b0; l_valid = 1'b0;
    @(negedge clk);
    check("rr_last_write", {31'd0, reg_write}, 32'd1);
    tick();
    @(negedge clk);
    check("rr_regwrite_off", {31'd0, reg_write}, 32'd0);

    // Reserve R0, then the ALU write to R0 clears it at its commit edge.
    res_valid = 1'b1; res_reg = 2'd0;
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("reserve_r0", {28'd0, busy}, 32'h1);
    a_valid = 1'b1; a_rd = 2'd0; a_wd = 16'hBEEF;
    exp_q.push_back({2'd0, 16'hBEEF});
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("r0_busy_before_commit", {28'd0, busy}, 32'h1);
    tick();
    @(negedge clk);
    check("r0_cleared", {28'd0, busy}, 32'h0);

    // Same-edge commit and re-reservation of R2.
    res_valid = 1'b1; res_reg = 2'd2;
    tick();
    res_valid = 1'b0;
    a_valid = 1'b1; a_rd = 2'd2; a_wd = 16'h2222;
    exp_q.push_back({2'd2, 16'h2222});
    tick();
    a_valid = 1'b0;
    res_valid = 1'b1; res_reg = 2'd2;
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("same_edge_busy", {28'd0, busy}, 32'h4);
    check("same_edge_noerr", {31'd0, res_error}, 32'd0);

    // Double reservation of R1 without a write in between.
    res_valid = 1'b1; res_reg = 2'd1;
    tick();
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("double_res_err", {31'd0, res_error}, 32'd1);
    check("double_res_busy", {28'd0, busy}, 32'h6);
    tick();
    tick();
    @(negedge clk);
    check("err_sticky", {31'd0, res_error}, 32'd1);

    // Reset while an accepted beat is in flight: it is dropped.
    a_valid = 1'b1; a_rd = 2'd3; a_wd = 16'hDEAD;
    tick();
    a_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_regwrite", {31'd0, reg_write}, 32'd0);
    check("rst_mid_busy", {28'd0, busy}, 32'h0);
    check("rst_mid_err", {31'd0, res_error}, 32'd0);
    tick();
    tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
